// File: rtl/branch_origin_writer.sv
// branch_origin_writer
// Write-side controller for the per-thread branch origin memory. Converts
// datapath I/O writes that land in the configuration window into registered
// origin-memory writes addressed by {thread, entry}, and sweeps every entry
// to CLEAR_VALUE after reset so no stale origin can match the PC.
module branch_origin_writer #(
  parameter int                        WORD_WIDTH        = 36,
  parameter int                        IO_ADDR_WIDTH     = 10,
  parameter logic [IO_ADDR_WIDTH-1:0]  BASE_ADDR         = 10'h3F0,
  parameter int                        THREAD_ADDR_WIDTH = 3,
  parameter int                        ENTRY_ADDR_WIDTH  = 1,
  parameter int                        ADDR_WIDTH        = 4,
  parameter int                        DEPTH             = 16,
  parameter logic [WORD_WIDTH-1:0]     CLEAR_VALUE       = '1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_wren,
  input  logic [IO_ADDR_WIDTH-1:0]     in_addr,
  input  logic [WORD_WIDTH-1:0]        in_data,
  input  logic [THREAD_ADDR_WIDTH-1:0] in_thread,
  output logic                         wren,
  output logic [ADDR_WIDTH-1:0]        write_addr,
  output logic [WORD_WIDTH-1:0]        write_data,
  output logic                         clearing,
  output logic                         dropped
);

  localparam int                       ENTRIES   = 2 ** ENTRY_ADDR_WIDTH;
  localparam logic [IO_ADDR_WIDTH-1:0] ENTRIES_W = IO_ADDR_WIDTH'(ENTRIES);
  localparam logic [ADDR_WIDTH-1:0]    LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    wren_q, wren_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WORD_WIDTH-1:0]   data_q, data_d;
  logic                    dropped_q, dropped_d;

  // Window decode: addresses below BASE_ADDR wrap to large offsets and miss.
  logic [IO_ADDR_WIDTH-1:0]    win_offset;
  logic                        win_hit;
  logic [ENTRY_ADDR_WIDTH-1:0] entry;

  assign win_offset = in_addr - BASE_ADDR;
  assign win_hit    = in_wren && (win_offset < ENTRIES_W);
  assign entry      = win_offset[ENTRY_ADDR_WIDTH-1:0];

  // Next-state and next-output logic for the clear sweep and run modes.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    wren_d    = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    dropped_d = dropped_q;
    case (state_q)
      ST_CLEAR: begin
        wren_d = 1'b1;
        addr_d = cnt_q;
        data_d = CLEAR_VALUE;
        cnt_d  = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end
        // Software writes cannot be honoured mid-sweep; flag the loss.
        if (win_hit) begin
          dropped_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (win_hit) begin
          wren_d = 1'b1;
          addr_d = {in_thread, entry};
          data_d = in_data;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset restarts the sweep.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= '0;
      wren_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wren_q    <= wren_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      dropped_q <= dropped_d;
    end
  end

  assign wren       = wren_q;
  assign write_addr = addr_q;
  assign write_data = data_q;
  assign clearing   = (state_q == ST_CLEAR);
  assign dropped    = dropped_q;

endmodule
